// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, imem handshake and IF/ID register
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        STALL,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc,
    input  logic        Jump,
    input  logic [31:0] Jump_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] address_final,
    output logic [31:0] Instruction,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_KILL,
        S_HOLD
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] hold_buf;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // Redirect target selection: branch beats jump, targets are word aligned
    always_comb begin
        redirect = branch_taken | Jump;
        target   = (branch_taken ? branch_pc : Jump_address) & 32'hFFFF_FFFC;
        pc_plus4 = pc + 32'd4;
    end

    assign pc_out    = pc;
    assign imem_addr = req_addr;

    // Fetch FSM: PC, request address, hold buffer and IF/ID register
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            pc            <= RESET_PC;
            req_addr      <= RESET_PC;
            imem_req      <= 1'b0;
            hold_buf      <= 32'h0;
            Instruction   <= NOP_INSTR;
            address_final <= 32'h0;
            if_id_valid   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                    req_addr <= pc;
                end

                S_REQ: begin
                    if (imem_ready) begin
                        if (redirect) begin
                            // Fetched word is on the wrong path; refetch at target
                            pc          <= target;
                            req_addr    <= target;
                            Instruction <= NOP_INSTR;
                            if_id_valid <= 1'b0;
                        end else if (!STALL) begin
                            Instruction   <= imem_rdata;
                            address_final <= pc_plus4;
                            if_id_valid   <= 1'b1;
                            pc            <= pc_plus4;
                            req_addr      <= pc_plus4;
                        end else begin
                            // Decode cannot take it yet; park the word and drop the request
                            hold_buf <= imem_rdata;
                            state    <= S_HOLD;
                            imem_req <= 1'b0;
                        end
                    end else if (redirect) begin
                        // Request stays on the bus; its data will be thrown away
                        pc          <= target;
                        Instruction <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        state       <= S_KILL;
                    end else if (!STALL) begin
                        Instruction <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                    end
                end

                S_KILL: begin
                    if (redirect) begin
                        pc <= target;
                    end
                    if (imem_ready) begin
                        req_addr <= redirect ? target : pc;
                        state    <= S_REQ;
                    end
                    if (redirect || !STALL) begin
                        Instruction <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                    end
                end

                S_HOLD: begin
                    if (redirect) begin
                        pc          <= target;
                        req_addr    <= target;
                        Instruction <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        state       <= S_REQ;
                        imem_req    <= 1'b1;
                    end else if (!STALL) begin
                        Instruction   <= hold_buf;
                        address_final <= pc_plus4;
                        if_id_valid   <= 1'b1;
                        pc            <= pc_plus4;
                        req_addr      <= pc_plus4;
                        state         <= S_REQ;
                        imem_req      <= 1'b1;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        STALL;
    logic        branch_taken;
    logic [31:0] branch_pc;
    logic        Jump;
    logic [31:0] Jump_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] address_final;
    logic [31:0] Instruction;
    logic        if_id_valid;

    int total  = 0;
    int passed = 0;

    logic [31:0] mem [logic [31:0]];

    // Reference model: transaction view of the fetch unit
    logic        m_started;
    logic        m_bus;
    logic        m_killed;
    logic        m_buffered;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic [31:0] m_buf;
    logic [31:0] m_instr;
    logic [31:0] m_af;
    logic        m_valid;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .STALL        (STALL),
        .branch_taken (branch_taken),
        .branch_pc    (branch_pc),
        .Jump         (Jump),
        .Jump_address (Jump_address),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .pc_out       (pc_out),
        .address_final(address_final),
        .Instruction  (Instruction),
        .if_id_valid  (if_id_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_bubble();
        m_instr = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_deliver(input logic [31:0] w);
        m_pc    = m_pc + 32'd4;
        m_instr = w;
        m_af    = m_pc;
        m_valid = 1'b1;
    endtask

    task automatic model_step(input logic rst, input logic st, input logic br, input logic [31:0] bpc,
                              input logic j, input logic [31:0] ja, input logic rdy);
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] word;
        redir = br | j;
        tgt   = (br ? bpc : ja) & 32'hFFFF_FFFC;
        if (rst) begin
            m_started = 0; m_bus = 0; m_killed = 0; m_buffered = 0;
            m_pc = 32'h0; m_addr = 32'h0; m_buf = 32'h0;
            m_instr = 32'h0; m_af = 32'h0; m_valid = 0;
        end else if (!m_started) begin
            m_started = 1; m_bus = 1; m_addr = m_pc;
        end else if (m_buffered) begin
            if (redir) begin
                m_buffered = 0; m_pc = tgt; m_addr = tgt; m_bus = 1; model_bubble();
            end else if (!st) begin
                model_deliver(m_buf); m_buffered = 0; m_bus = 1; m_addr = m_pc;
            end
        end else if (rdy) begin
            word = mem_word(m_addr);
            if (redir) begin
                m_pc = tgt; m_addr = tgt; m_killed = 0; model_bubble();
            end else if (m_killed) begin
                m_killed = 0; m_addr = m_pc;
                if (!st) model_bubble();
            end else if (st) begin
                m_buf = word; m_buffered = 1; m_bus = 0;
            end else begin
                model_deliver(word); m_addr = m_pc;
            end
        end else begin
            if (redir) begin
                m_pc = tgt; m_killed = 1; model_bubble();
            end else if (!st) begin
                model_bubble();
            end
        end
    endtask

    task automatic drive(input logic rst, input logic st, input logic br, input logic [31:0] bpc,
                         input logic j, input logic [31:0] ja, input logic rdy);
        reset        = rst;
        STALL        = st;
        branch_taken = br;
        branch_pc    = bpc;
        Jump         = j;
        Jump_address = ja;
        imem_ready   = rdy;
        imem_rdata   = rst ? 32'h0 : mem_word(imem_addr);
        model_step(rst, st, br, bpc, j, ja, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1);
        total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else passed++;
        total++; if (imem_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", imem_addr); else passed++;
        total++; if (pc_out !== 32'h0) $display("FAIL rst_pc: got %h want 0", pc_out); else passed++;
        total++; if (Instruction !== 32'h0) $display("FAIL rst_instr: got %h want 0", Instruction); else passed++;
        total++; if (address_final !== 32'h0) $display("FAIL rst_af: got %h want 0", address_final); else passed++;
        total++; if (if_id_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", if_id_valid); else passed++;
    endtask

    task automatic test_sequential();
        drive(0, 0, 0, 0, 0, 0, 1);
        total++; if (imem_req !== 1'b1) $display("FAIL seq_req: got %b want 1", imem_req); else passed++;
        total++; if (imem_addr !== 32'h0) $display("FAIL seq_addr0: got %h want 0", imem_addr); else passed++;
        drive(0, 0, 0, 0, 0, 0, 1);
        total++; if (Instruction !== 32'h2001_0005) $display("FAIL seq_i0: got %h want 20010005", Instruction); else passed++;
        total++; if (address_final !== 32'h4) $display("FAIL seq_af0: got %h want 4", address_final); else passed++;
        total++; if (if_id_valid !== 1'b1) $display("FAIL seq_v0: got %b want 1", if_id_valid); else passed++;
        drive(0, 0, 0, 0, 0, 0, 1);
        total++; if (Instruction !== 32'h2002_0007) $display("FAIL seq_i1: got %h want 20020007", Instruction); else passed++;
        total++; if (address_final !== 32'h8) $display("FAIL seq_af1: got %h want 8", address_final); else passed++;
        total++; if (if_id_valid !== 1'b1) $display("FAIL seq_v1: got %b want 1", if_id_valid); else passed++;
        total++; if (imem_addr !== 32'h8) $display("FAIL seq_addr2: got %h want 8", imem_addr); else passed++;
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 0, 0, 0, 1);
            total++; if (Instruction !== 32'h2002_0007) $display("FAIL stall_instr[%0d]: got %h want 20020007", k, Instruction); else passed++;
            total++; if (pc_out !== 32'h8) $display("FAIL stall_pc[%0d]: got %h want 8", k, pc_out); else passed++;
            total++; if (imem_req !== 1'b0) $display("FAIL stall_req[%0d]: got %b want 0", k, imem_req); else passed++;
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        total++; if (Instruction !== 32'h8C01_0000) $display("FAIL stall_rel_instr: got %h want 8c010000", Instruction); else passed++;
        total++; if (address_final !== 32'hC) $display("FAIL stall_rel_af: got %h want c", address_final); else passed++;
        total++; if (imem_req !== 1'b1) $display("FAIL stall_rel_req: got %b want 1", imem_req); else passed++;
        total++; if (imem_addr !== 32'hC) $display("FAIL stall_rel_addr: got %h want c", imem_addr); else passed++;
    endtask

    task automatic test_branch();
        drive(0, 0, 1, 32'h40, 0, 0, 1);
        total++; if (if_id_valid !== 1'b0) $display("FAIL br_valid: got %b want 0", if_id_valid); else passed++;
        total++; if (Instruction !== 32'h0) $display("FAIL br_nop: got %h want 0", Instruction); else passed++;
        total++; if (imem_addr !== 32'h40) $display("FAIL br_addr: got %h want 40", imem_addr); else passed++;
        total++; if (address_final !== 32'hC) $display("FAIL br_af_hold: got %h want c", address_final); else passed++;
        drive(0, 0, 0, 0, 0, 0, 1);
        total++; if (Instruction !== mem_word(32'h40)) $display("FAIL br_instr: got %h want %h", Instruction, mem_word(32'h40)); else passed++;
        total++; if (address_final !== 32'h44) $display("FAIL br_af: got %h want 44", address_final); else passed++;
    endtask

    task automatic test_jump_wait();
        drive(0, 0, 0, 0, 1, 32'h100, 0);
        total++; if (imem_addr !== 32'h44) $display("FAIL jw_addr0: got %h want 44", imem_addr); else passed++;
        total++; if (imem_req !== 1'b1) $display("FAIL jw_req: got %b want 1", imem_req); else passed++;
        total++; if (pc_out !== 32'h100) $display("FAIL jw_pc: got %h want 100", pc_out); else passed++;
        drive(0, 0, 0, 0, 0, 0, 0);
        total++; if (imem_addr !== 32'h44) $display("FAIL jw_addr1: got %h want 44", imem_addr); else passed++;
        drive(0, 0, 0, 0, 0, 0, 1);
        total++; if (imem_addr !== 32'h100) $display("FAIL jw_addr2: got %h want 100", imem_addr); else passed++;
        total++; if (if_id_valid !== 1'b0) $display("FAIL jw_discard: got %b want 0", if_id_valid); else passed++;
        drive(0, 0, 0, 0, 0, 0, 1);
        total++; if (Instruction !== mem_word(32'h100)) $display("FAIL jw_instr: got %h want %h", Instruction, mem_word(32'h100)); else passed++;
        total++; if (address_final !== 32'h104) $display("FAIL jw_af: got %h want 104", address_final); else passed++;
    endtask

    task automatic test_both_redirect();
        drive(0, 1, 1, 32'h300, 1, 32'h200, 1);
        total++; if (pc_out !== 32'h300) $display("FAIL both_pc: got %h want 300", pc_out); else passed++;
        total++; if (if_id_valid !== 1'b0) $display("FAIL both_valid: got %b want 0", if_id_valid); else passed++;
        total++; if (Instruction !== 32'h0) $display("FAIL both_nop: got %h want 0", Instruction); else passed++;
        drive(0, 0, 0, 0, 0, 0, 1);
        total++; if (Instruction !== mem_word(32'h300)) $display("FAIL both_instr: got %h want %h", Instruction, mem_word(32'h300)); else passed++;
    endtask

    task automatic test_wrap();
        drive(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 1);
        total++; if (pc_out !== 32'hFFFF_FFFC) $display("FAIL wrap_pc: got %h want fffffffc", pc_out); else passed++;
        drive(0, 0, 0, 0, 0, 0, 1);
        total++; if (address_final !== 32'h0) $display("FAIL wrap_af: got %h want 0", address_final); else passed++;
        total++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr: got %h want 0", imem_addr); else passed++;
        total++; if (Instruction !== mem_word(32'hFFFF_FFFC)) $display("FAIL wrap_instr: got %h want %h", Instruction, mem_word(32'hFFFF_FFFC)); else passed++;
    endtask

    task automatic test_reset_in_kill();
        drive(0, 0, 0, 0, 1, 32'h80, 0);
        total++; if (pc_out !== 32'h80) $display("FAIL kill_pc: got %h want 80", pc_out); else passed++;
        drive(1, 0, 0, 0, 0, 0, 1);
        total++; if (imem_req !== 1'b0) $display("FAIL krst_req: got %b want 0", imem_req); else passed++;
        total++; if (imem_addr !== 32'h0) $display("FAIL krst_addr: got %h want 0", imem_addr); else passed++;
        total++; if (pc_out !== 32'h0) $display("FAIL krst_pc: got %h want 0", pc_out); else passed++;
        total++; if (Instruction !== 32'h0) $display("FAIL krst_instr: got %h want 0", Instruction); else passed++;
        total++; if (address_final !== 32'h0) $display("FAIL krst_af: got %h want 0", address_final); else passed++;
        total++; if (if_id_valid !== 1'b0) $display("FAIL krst_valid: got %b want 0", if_id_valid); else passed++;
    endtask

    task automatic test_random();
        logic rst, st, br, j, rdy;
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 9) == 0);
            j   = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            drive(rst, st, br, $urandom, j, $urandom, rdy);
            total++; if (imem_req !== m_bus) $display("FAIL rnd_req @%0d: got %b want %b", i, imem_req, m_bus); else passed++;
            total++; if (imem_addr !== m_addr) $display("FAIL rnd_addr @%0d: got %h want %h", i, imem_addr, m_addr); else passed++;
            total++; if (pc_out !== m_pc) $display("FAIL rnd_pc @%0d: got %h want %h", i, pc_out, m_pc); else passed++;
            total++; if (Instruction !== m_instr) $display("FAIL rnd_instr @%0d: got %h want %h", i, Instruction, m_instr); else passed++;
            total++; if (address_final !== m_af) $display("FAIL rnd_af @%0d: got %h want %h", i, address_final, m_af); else passed++;
            total++; if (if_id_valid !== m_valid) $display("FAIL rnd_valid @%0d: got %b want %b", i, if_id_valid, m_valid); else passed++;
        end
    endtask

    initial begin
        mem[32'h0] = 32'h2001_0005;
        mem[32'h4] = 32'h2002_0007;
        mem[32'h8] = 32'h8C01_0000;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jump_wait();
        test_both_redirect();
        test_wrap();
        test_reset_in_kill();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register, sitting directly upstream of the Decode stage. It owns the PC, issues requests to instruction memory over a req/ready handshake, and selects the next PC from PC+4, the branch target and the jump target. It presents the registered instruction and PC+4 (address_final) to Decode, honours the hazard-unit STALL, and inserts bubbles on redirects.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction word used for bubbles (sll $0,$0,0).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
STALL  input  1  hazard-unit stall; holds PC and IF/ID contents
branch_taken  input  1  Branch AND zero; redirect to branch_pc
branch_pc  input  32  branch target from Decode
Jump  input  1  jump redirect to Jump_address
Jump_address  input  32  jump target from Decode
imem_req  output  1  instruction-memory request valid
imem_addr  output  32  word address of the outstanding request
imem_ready  input  1  imem accepted the request; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
pc_out  output  32  current PC (Decode uses bits [31:28] for jumps)
address_final  output  32  IF/ID registered PC+4
Instruction  output  32  IF/ID registered instruction
if_id_valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble

Behaviour:
- One clock, synchronous active-high reset; everything sampled on the rising edge of clk.
- Reset values: PC=RESET_PC, state=S_IDLE, imem_req=0, imem_addr=RESET_PC, Instruction=NOP_INSTR, address_final=0, if_id_valid=0, hold buffer=0. Reset mid-request drops the outstanding request; imem must tolerate imem_req falling without ready.
- Redirect: redirect = branch_taken | Jump. Target = branch_pc if branch_taken, else Jump_address. Branch has priority when both are asserted. Target bits [1:0] are forced to 0. Redirect takes priority over STALL: the IF/ID register loads a bubble even when STALL=1.
- Bubble: Instruction=NOP_INSTR, address_final unchanged, if_id_valid=0.
- PC increment is PC+4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- imem_addr is a registered copy (req_addr) captured when a request starts. It stays constant while imem_req=1 until imem_ready.
- S_IDLE: imem_req=0. Next state is S_REQ with req_addr=PC. Entered only from reset.
- S_REQ: imem_req=1.
  - ready and redirect: discard the data, PC=target, req_addr=target, IF/ID bubble, stay in S_REQ.
  - ready, no redirect, STALL=0: IF/ID={PC+4, imem_rdata, valid=1}, PC=PC+4, req_addr=PC+4, stay in S_REQ. Throughput is 1 instruction/cycle with a zero-wait memory.
  - ready, no redirect, STALL=1: hold buffer=imem_rdata, IF/ID unchanged, go to S_HOLD.
  - no ready and redirect: PC=target, IF/ID bubble, go to S_KILL.
  - no ready, no redirect: IF/ID holds if STALL=1, else loads a bubble.
- S_KILL: imem_req=1, imem_addr=old req_addr (the request is not withdrawn).
  - Further redirects update PC; stay in S_KILL.
  - On ready: discard imem_rdata, req_addr=PC (the latest target), go to S_REQ.
  - IF/ID loads a bubble each cycle unless STALL=1 with no redirect.
- S_HOLD: imem_req=0.
  - redirect: drop the buffer, PC=target, req_addr=target, IF/ID bubble, go to S_REQ.
  - STALL=0: IF/ID={PC+4, buffer, valid=1}, PC=PC+4, req_addr=PC+4, go to S_REQ.
  - STALL=1: hold.
- pc_out = PC register, always.
- Load-use latency: an instruction accepted with ready at cycle N is visible on Instruction at cycle N+1.

Test Plan:
- Reset, then imem_ready=1 always, rdata=0x2001_0005 at 0x0, 0x2002_0007 at 0x4: cycle 1 has imem_req=1 and imem_addr=0x0. Instruction=0x2001_0005 with address_final=0x4, then 0x2002_0007 with 0x8. if_id_valid=1 each cycle.
- STALL=1 for 3 cycles while ready returns 0x8C01_0000: IF/ID and pc_out are frozen and state is S_HOLD. After STALL drops, Instruction=0x8C01_0000 on the next edge and fetch resumes at PC+4.
- branch_taken=1, branch_pc=0x0000_0040, same-cycle ready: the next Instruction is NOP with if_id_valid=0. The next imem_addr is 0x40 and the following instruction comes from 0x40.
- Redirect while ready=0 (Jump=1, Jump_address=0x0000_0100): imem_addr stays at the old address until ready. Those data are discarded and the next request is 0x100.
- Jump and branch_taken both set (0x200 / 0x300), plus STALL=1: PC=0x300 (branch wins) and IF/ID becomes a bubble despite STALL.
- PC preset by redirect to 0xFFFF_FFFC, fetch one instruction: address_final=0x0000_0000 and the next imem_addr is 0x0. Reset asserted mid-S_KILL returns all outputs to reset values on the next edge.
